pc_predict_unit: RTL and testbench

//  Fetch-stage program counter with next-PC selection, EX-stage branch/jump resolution
//  and an optional direct-mapped branch target buffer (BTB) with 2-bit saturating counters.

---
 rtl/pc_predict_unit.sv | 160 ++++++++++++++++
 tb/tb_pc_predict_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// rtl/pc_predict_unit.sv - fetch PC register with next-PC prediction and EX-stage redirect
// Optional feature macro: PC_PREDICT_BTB_EN builds the direct-mapped BTB with 2-bit counters;
//   without it the unit predicts static not-taken (pred_taken=0, pred_target=pc_plus_4).
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   stall                hold the fetch PC
//   resolve_valid        EX has a resolved branch/jump this cycle
//   resolve_is_branch    1=conditional branch, 0=unconditional jump
//   resolve_pc           PC of the resolving instruction
//   resolve_taken        actual direction
//   resolve_target       actual taken target
//   resolve_pred_taken   direction predicted at fetch, carried down the pipe
//   resolve_pred_target  target predicted at fetch, carried down the pipe
//   pc, pc_plus_4        current fetch PC and its sequential successor
//   pred_taken           prediction for the instruction at pc
//   pred_target          predicted next PC for the instruction at pc
//   flush                misprediction, kill IF/ID this cycle (combinational)
module pc_predict_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            resolve_valid,
   input  logic            resolve_is_branch,
   input  logic [XLEN-1:0] resolve_pc,
   input  logic            resolve_taken,
   input  logic [XLEN-1:0] resolve_target,
   input  logic            resolve_pred_taken,
   input  logic [XLEN-1:0] resolve_pred_target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_4,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   output logic            flush
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] correct_pc;
   logic            mispredict;

   assign pc        = pc_q;
   assign pc_plus_4 = pc_q + XLEN'(4);

   // A taken outcome is wrong if either the direction or the target was wrong;
   // a not-taken outcome only needs the direction to match.
   assign mispredict = resolve_valid &
                       ((resolve_taken != resolve_pred_taken) |
                        (resolve_taken & (resolve_pred_target != resolve_target)));

   // Keep flush quiet while reset is held, even if EX inputs look like a mispredict.
   assign flush = mispredict & rst_n;

   assign correct_pc = resolve_taken ? {resolve_target[XLEN-1:2], 2'b00}
                                     : resolve_pc + XLEN'(4);

   // Mispredict redirect wins over stall: the wrong-path instructions are being killed anyway.
   always_comb begin
      pc_d = pc_q;
      if (mispredict) begin
         pc_d = correct_pc;
      end else if (!stall) begin
         pc_d = pred_target;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

`ifdef PC_PREDICT_BTB_EN
   localparam int IDX  = $clog2(BTB_ENTRIES);
   localparam int TAGW = XLEN - IDX - 2;

   logic            valid_q  [BTB_ENTRIES];
   logic            valid_d  [BTB_ENTRIES];
   logic [1:0]      ctr_q    [BTB_ENTRIES];
   logic [1:0]      ctr_d    [BTB_ENTRIES];
   logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
   logic [TAGW-1:0] tag_d    [BTB_ENTRIES];
   logic [XLEN-1:0] target_q [BTB_ENTRIES];
   logic [XLEN-1:0] target_d [BTB_ENTRIES];

   logic [IDX-1:0]  rd_idx;
   logic [TAGW-1:0] rd_tag;
   logic            rd_hit;
   logic [IDX-1:0]  wr_idx;
   logic [TAGW-1:0] wr_tag;
   logic            wr_hit;

   // Lookup reads the registered arrays, so a same-cycle update to the same
   // index is only seen by the following cycle's lookup.
   assign rd_idx      = pc_q[IDX+1:2];
   assign rd_tag      = pc_q[XLEN-1:IDX+2];
   assign rd_hit      = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
   assign pred_taken  = rd_hit & ctr_q[rd_idx][1];
   assign pred_target = pred_taken ? target_q[rd_idx] : pc_plus_4;

   assign wr_idx = resolve_pc[IDX+1:2];
   assign wr_tag = resolve_pc[XLEN-1:IDX+2];
   assign wr_hit = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);

   // Training is independent of stall: the resolving instruction is already in EX.
   always_comb begin
      valid_d  = valid_q;
      ctr_d    = ctr_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (resolve_valid) begin
         if (wr_hit) begin
            if (resolve_taken) begin
               if (ctr_q[wr_idx] != 2'b11) begin
                  ctr_d[wr_idx] = ctr_q[wr_idx] + 2'b01;
               end
               target_d[wr_idx] = resolve_target;
            end else if (ctr_q[wr_idx] != 2'b00) begin
               ctr_d[wr_idx] = ctr_q[wr_idx] - 2'b01;
            end
         end else if (resolve_taken) begin
            // New entries start weakly taken; jumps always go, so start them strong.
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = resolve_target;
            ctr_d[wr_idx]    = resolve_is_branch ? 2'b10 : 2'b11;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            ctr_q[i]    <= 2'b01;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else begin
         valid_q  <= valid_d;
         ctr_q    <= ctr_d;
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end
`else
   assign pred_taken  = 1'b0;
   assign pred_target = pc_plus_4;

   // Branch/jump kind only matters for BTB allocation.
   logic unused_is_branch;
   assign unused_is_branch = resolve_is_branch;
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// tb/tb_pc_predict_unit.sv - self-checking bench for pc_predict_unit
module tb_pc_predict_unit;

`ifdef PC_PREDICT_BTB_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif
   localparam logic [31:0] RST_PC = 32'h100;
   localparam int          N      = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, rv, isbr, tk, ptk;
   logic [31:0] rpc, tgt, ptgt;
   logic [31:0] pc, pc_plus_4, pred_target;
   logic        pred_taken, flush;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_predict_unit #(
      .XLEN        (32),
      .RESET_PC    (RST_PC),
      .BTB_ENTRIES (N)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .stall               (stall),
      .resolve_valid       (rv),
      .resolve_is_branch   (isbr),
      .resolve_pc          (rpc),
      .resolve_taken       (tk),
      .resolve_target      (tgt),
      .resolve_pred_taken  (ptk),
      .resolve_pred_target (ptgt),
      .pc                  (pc),
      .pc_plus_4           (pc_plus_4),
      .pred_taken          (pred_taken),
      .pred_target         (pred_target),
      .flush               (flush)
   );

   // Reference model: BTB as plain arrays indexed by word address modulo N.
   logic [31:0] m_pc;
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];

   typedef struct {
      bit          s, v, b;
      logic [31:0] a;
      bit          t;
      logic [31:0] g;
      bit          p;
      logic [31:0] pg;
      bit          ef;
      logic [31:0] en;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC;
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
      end
   endtask

   function automatic void m_lookup(input logic [31:0] a, output bit t, output logic [31:0] nt);
      int i;
      bit hit;
      i   = int'((a >> 2) % N);
      hit = BTB && m_valid[i] && (m_tag[i] == (a >> ($clog2(N) + 2)));
      t   = hit && (m_ctr[i] >= 2);
      nt  = t ? m_tgt[i] : a + 32'd4;
   endfunction

   function automatic bit m_mis();
      return rv && ((tk != ptk) || (tk && (ptgt != tgt)));
   endfunction

   task automatic check_model();
      bit          et;
      logic [31:0] en;
      m_lookup(m_pc, et, en);
      chk("pc", pc, m_pc);
      chk("pc_plus_4", pc_plus_4, m_pc + 32'd4);
      chk("pred_taken", pred_taken, et);
      chk("pred_target", pred_target, en);
      chk("flush", flush, m_mis());
   endtask

   // Advance one clock: compute the model's next state from the held inputs.
   task automatic tick();
      bit          et, mis, hit;
      logic [31:0] en, nxt;
      int          i;
      m_lookup(m_pc, et, en);
      mis = m_mis();
      if (mis)        nxt = tk ? (tgt & 32'hFFFF_FFFC) : rpc + 32'd4;
      else if (stall) nxt = m_pc;
      else            nxt = en;
      if (BTB && rv) begin
         i   = int'((rpc >> 2) % N);
         hit = m_valid[i] && (m_tag[i] == (rpc >> ($clog2(N) + 2)));
         if (hit) begin
            if (tk) begin
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_tgt[i] = tgt;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = rpc >> ($clog2(N) + 2);
            m_tgt[i]   = tgt;
            m_ctr[i]   = isbr ? 2 : 3;
         end
      end
      @(posedge clk);
      #1;
      m_pc = nxt;
   endtask

   task automatic drive(input bit s, input bit v, input bit b, input logic [31:0] a,
                        input bit t, input logic [31:0] g, input bit p, input logic [31:0] pg);
      stall = s; rv = v; isbr = b; rpc = a; tk = t; tgt = g; ptk = p; ptgt = pg;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
   endtask

   task automatic step();
      #4;
      check_model();
      tick();
   endtask

   // Redirect fetch to addr with a mispredicted jump from an otherwise unused address.
   task automatic goto(input logic [31:0] addr);
      drive(0, 1, 0, 32'h1F0, 1, addr, 0, 32'h0);
      step();
      idle();
   endtask

   initial begin
      bit          et;
      logic [31:0] en;

      tbl[0] = '{0, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h110};
      tbl[1] = '{1, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h110};
      tbl[2] = '{0, 1, 1, 32'h800, 1, 32'h140, 0, 32'h000, 1, 32'h140};
      tbl[3] = '{0, 1, 1, 32'h804, 0, 32'h000, 0, 32'h000, 0, 32'h144};
      tbl[4] = '{0, 1, 1, 32'h808, 1, 32'h180, 1, 32'h180, 0, 32'h148};
      tbl[5] = '{0, 1, 1, 32'h808, 1, 32'h184, 1, 32'h180, 1, 32'h184};
      tbl[6] = '{0, 1, 1, 32'h80C, 0, 32'h000, 1, 32'h000, 1, 32'h810};
      tbl[7] = '{1, 1, 0, 32'h900, 1, 32'h143, 0, 32'h000, 1, 32'h140};
      tbl[8] = '{1, 0, 0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 32'h140};
      tbl[9] = '{0, 1, 1, 32'h904, 0, 32'h000, 0, 32'h000, 0, 32'h144};

      // Reset with a would-be mispredict on the EX inputs.
      rst_n = 1'b0;
      drive(0, 1, 1, 32'h200, 1, 32'h40, 0, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h100);
      chk("rst_pred_taken", pred_taken, 0);
      chk("rst_flush", flush, 0);
      idle();
      rst_n = 1'b1;

      // Sequential fetch after reset.
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("seq_pc", pc, RST_PC + 32'(4 * k));
      end

      // Table-driven vectors from pc=0x10C.
      for (int k = 0; k < 10; k++) begin
         drive(tbl[k].s, tbl[k].v, tbl[k].b, tbl[k].a, tbl[k].t, tbl[k].g, tbl[k].p, tbl[k].pg);
         #4;
         check_model();
         chk("tbl_flush", flush, tbl[k].ef);
         tick();
         chk("tbl_next_pc", pc, tbl[k].en);
      end
      idle();

      // Cold taken branch, then fetch it again.
      drive(0, 1, 1, 32'h200, 1, 32'h40, 0, 32'h0);
      #4;
      check_model();
      chk("cold_flush", flush, 1);
      tick();
      chk("cold_pc", pc, 32'h40);
      idle();
      goto(32'h200);
      #4;
      check_model();
      chk("cold_pred_taken", pred_taken, BTB);
      chk("cold_pred_target", pred_target, BTB ? 32'h40 : 32'h204);
      tick();

      // Counter walks down and saturates at 00, then climbs back.
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 1, 32'h200, 0, 32'h0, (k == 0) ? BTB : 1'b0, 32'h40);
         step();
         goto(32'h200);
         #4;
         check_model();
         chk("sat_down_pred", pred_taken, 0);
         tick();
      end
      drive(0, 1, 1, 32'h200, 1, 32'h40, 0, 32'h0);
      step();
      goto(32'h200);
      #4;
      check_model();
      chk("sat_hold_pred", pred_taken, 0);
      tick();
      drive(0, 1, 1, 32'h200, 1, 32'h40, 0, 32'h0);
      step();
      goto(32'h200);
      #4;
      check_model();
      chk("sat_up_pred", pred_taken, BTB);
      tick();

      // Mispredict overrides stall, then stall alone holds pc.
      drive(1, 1, 1, 32'h600, 0, 32'h0, 1, 32'h0);
      #4;
      check_model();
      chk("stall_mis_flush", flush, 1);
      tick();
      chk("stall_mis_pc", pc, 32'h604);
      drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_hold_pc", pc, 32'h604);
      end
      idle();

      // Aliasing: same index as 0x200, different tag.
      goto(32'h200 + 32'(4 * N));
      #4;
      check_model();
      chk("alias_pred_taken", pred_taken, 0);
      chk("alias_pred_target", pred_target, 32'h244);
      tick();

      // Wrap at the top of the address space.
      goto(32'hFFFF_FFFC);
      #4;
      check_model();
      chk("wrap_pc_plus_4", pc_plus_4, 32'h0);
      chk("wrap_pred_target", pred_target, 32'h0);
      tick();
      chk("wrap_pc", pc, 32'h0);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a, g;
         bit          b, t;
         a = 32'h200 + 32'(4 * $urandom_range(0, 15)) + (($urandom_range(0, 1) == 1) ? 32'h400 : 32'h0);
         g = 32'h200 + 32'(4 * $urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) g = g | 32'($urandom_range(0, 3));
         b = ($urandom_range(0, 3) != 0);
         t = b ? 1'($urandom_range(0, 1)) : 1'b1;
         m_lookup(a, et, en);
         if ($urandom_range(0, 1) == 1) begin
            et = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 1) == 1) ? g : en;
         end
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) < 2), b, a, t, g, et, en);
         step();
      end

      // Asynchronous reset mid-cycle.
      drive(0, 1, 1, 32'h200, 1, 32'h40, 0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc", pc, 32'h100);
      chk("async_rst_flush", flush, 0);
      chk("async_rst_pred", pred_taken, 0);
      model_reset();
      @(posedge clk);
      #1;
      chk("async_rst_hold_pc", pc, 32'h100);
      idle();
      rst_n = 1'b1;
      goto(32'h200);
      #4;
      check_model();
      chk("rst_btb_cleared", pred_taken, 0);
      tick();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
